fetch_unit: RTL and testbench

Parametrised instruction-fetch stage, the successor to the single-cycle PC/ROM pair. It owns the PC, drives a synchronous (1-cycle read latency) instruction memory, and presents one instruction per cycle to decode with a valid flag and its PC. It adds stall handling with a one-entry hold buffer, PC-relative and absolute redirects, a configurable reset vector, and misalignment flagging.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage that owns the PC, drives a 1-cycle
//               synchronous instruction memory and hands one instruction per
//               cycle to decode, with a stall hold buffer and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int                       INSTR_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic                     redirect_sel,
    input  logic [ADDRESS_WIDTH-1:0] redirect_base,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic [ADDRESS_WIDTH-1:0] next_PC,
    output logic                     instr_valid,
    output logic                     redirect_misaligned
);

    localparam int                       C_ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] C_STEP       = ADDRESS_WIDTH'(INSTR_BYTES);

    logic [ADDRESS_WIDTH-1:0] pc_q,         pc_d;
    logic [ADDRESS_WIDTH-1:0] d_pc_q,       d_pc_d;
    logic                     d_valid_q,    d_valid_d;
    logic                     hold_q,       hold_d;
    logic [DATA_WIDTH-1:0]    hold_instr_q, hold_instr_d;

    logic [ADDRESS_WIDTH-1:0] w_sum;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     w_target_unaligned;

    assign w_sum    = redirect_base + ImmOp;
    // Absolute jumps drop bit 0 of the computed address, as JALR does.
    assign w_target = redirect_sel ? {w_sum[ADDRESS_WIDTH-1:1], 1'b0} : w_sum;

    generate
        if (C_ALIGN_BITS > 0) begin : g_align_check
            assign w_target_unaligned = |w_target[C_ALIGN_BITS-1:0];
        end else begin : g_no_align_check
            assign w_target_unaligned = 1'b0;
        end
    endgenerate

    assign redirect_misaligned = redirect_valid && w_target_unaligned;

    assign imem_addr   = pc_q;
    assign instr       = hold_q ? hold_instr_q : imem_rdata;
    assign instr_pc    = d_pc_q;
    assign instr_valid = d_valid_q;
    assign next_PC     = d_pc_q + C_STEP;

    always_comb begin
        pc_d         = pc_q;
        d_pc_d       = d_pc_q;
        d_valid_d    = d_valid_q;
        hold_d       = hold_q;
        hold_instr_d = hold_instr_q;
        if (redirect_valid) begin
            pc_d      = w_target;
            d_valid_d = 1'b0;
            hold_d    = 1'b0;
        end else if (stall) begin
            // Memory keeps re-reading pc_q, so the word on imem_rdata is only
            // trustworthy in the first stalled cycle; capture it there.
            if (d_valid_q && !hold_q) begin
                hold_instr_d = imem_rdata;
                hold_d       = 1'b1;
            end
        end else begin
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
            pc_d      = pc_q + C_STEP;
            hold_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            d_pc_q       <= RESET_VECTOR;
            d_valid_q    <= 1'b0;
            hold_q       <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            d_pc_q       <= d_pc_d;
            d_valid_q    <= d_valid_d;
            hold_q       <= hold_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               randomized run against a reference model, reset-vector wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (RESET_VECTOR = 0) ----------------
    logic        rst, stall, rv, sel;
    logic [31:0] base, imm;
    logic [31:0] addr1, rdata1, ins1, pc1, npc1;
    logic        v1, mis1;

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_sel(sel),
        .redirect_base(base), .ImmOp(imm), .imem_addr(addr1), .imem_rdata(rdata1),
        .instr(ins1), .instr_pc(pc1), .next_PC(npc1), .instr_valid(v1),
        .redirect_misaligned(mis1)
    );

    // ---------------- DUT 2 (RESET_VECTOR = 0xFFFFFFF8) ----------------
    logic        rst2;
    logic        z1  = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic [31:0] addr2, rdata2, ins2, pc2, npc2;
    logic        v2, mis2;

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8), .INSTR_BYTES(4)) dut2 (
        .clk(clk), .rst(rst2), .stall(z1), .redirect_valid(z1), .redirect_sel(z1),
        .redirect_base(z32), .ImmOp(z32), .imem_addr(addr2), .imem_rdata(rdata2),
        .instr(ins2), .instr_pc(pc2), .next_PC(npc2), .instr_valid(v2),
        .redirect_misaligned(mis2)
    );

    // ROM word[i] = 0x1000 + i, word index = byte address / 4.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        rdata1 <= rom(addr1);
        rdata2 <= rom(addr2);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, stall, rv, sel;
        logic [31:0] base, imm;
        logic        ev;
        logic [31:0] epc, eaddr;
        logic        emis;
    } vec_t;

    function automatic vec_t mk(input logic r, s, v, sl, input logic [31:0] b, i,
                                input logic ev, input logic [31:0] epc, ea, input logic em);
        vec_t t;
        t.rst = r; t.stall = s; t.rv = v; t.sel = sl; t.base = b; t.imm = i;
        t.ev = ev; t.epc = epc; t.eaddr = ea; t.emis = em;
        return t;
    endfunction

    vec_t tbl[30];

    // Reference model: decode-visible view only (what is shown, what is fetched next).
    logic        m_valid;
    logic [31:0] m_pc, m_fetch;

    task automatic model_edge(input logic r, s, v, sl, input logic [31:0] b, i);
        logic [31:0] t;
        t = b + i;
        if (sl) t = t & ~32'h1;
        if (r) begin
            m_valid = 1'b0; m_fetch = 32'h0; m_pc = 32'h0;
        end else if (v) begin
            m_valid = 1'b0; m_fetch = t;
        end else if (!s) begin
            m_valid = 1'b1; m_pc = m_fetch; m_fetch = m_fetch + 32'd4;
        end
    endtask

    function automatic logic exp_mis(input logic v, sl, input logic [31:0] b, i);
        logic [31:0] t;
        t = b + i;
        if (sl) t = t & ~32'h1;
        return v && (t[1:0] != 2'b00);
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; sel = 1'b0; base = '0; imm = '0;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //            rst  stl  rv   sel  base          imm           ev   epc           addr          mis
        tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h0,        1'b0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h0,        1'b0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h0,        32'h4,        1'b0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h4,        32'h8,        1'b0);
        tbl[4]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8,        32'hC,        1'b0);
        tbl[5]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8,        32'hC,        1'b0);
        tbl[6]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8,        32'hC,        1'b0);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8,        32'hC,        1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'hC,        32'h10,       1'b0);
        tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0,32'h10,       32'hFFFF_FFF8,1'b1,32'h10,       32'h14,       1'b0);
        tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h8,        1'b0);
        tbl[11] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8,        32'hC,        1'b0);
        tbl[12] = mk(1'b0,1'b0,1'b1,1'b1,32'h21,       32'h2,        1'b1,32'hC,        32'h10,       1'b1);
        tbl[13] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h22,       1'b0);
        tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h22,       32'h26,       1'b0);
        tbl[15] = mk(1'b0,1'b0,1'b1,1'b1,32'h20,       32'h1,        1'b1,32'h26,       32'h2A,       1'b0);
        tbl[16] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h20,       1'b0);
        tbl[17] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h20,       32'h24,       1'b0);
        tbl[18] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h20,       32'h24,       1'b0);
        tbl[19] = mk(1'b0,1'b1,1'b1,1'b0,32'h100,      32'h40,       1'b1,32'h20,       32'h24,       1'b0);
        tbl[20] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h140,      1'b0);
        tbl[21] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h140,      32'h144,      1'b0);
        tbl[22] = mk(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h144,      32'h148,      1'b0);
        tbl[23] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h0,        1'b0);
        tbl[24] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h0,        32'h4,        1'b0);
        tbl[25] = mk(1'b0,1'b0,1'b1,1'b0,32'h80,       32'h0,        1'b1,32'h4,        32'h8,        1'b0);
        tbl[26] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h80,       1'b0);
        tbl[27] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h80,       1'b0);
        tbl[28] = mk(1'b0,1'b0,1'b0,1'b1,32'h3,        32'h0,        1'b0,32'h0,        32'h80,       1'b0);
        tbl[29] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h80,       32'h84,       1'b0);

        for (int k = 0; k < 30; k++) begin
            rst = tbl[k].rst; stall = tbl[k].stall; rv = tbl[k].rv; sel = tbl[k].sel;
            base = tbl[k].base; imm = tbl[k].imm;
            @(negedge clk);
            chk($sformatf("tbl%0d instr_valid", k), {31'b0, v1}, {31'b0, tbl[k].ev});
            chk($sformatf("tbl%0d imem_addr", k), addr1, tbl[k].eaddr);
            chk($sformatf("tbl%0d misaligned", k), {31'b0, mis1}, {31'b0, tbl[k].emis});
            if (tbl[k].ev) begin
                chk($sformatf("tbl%0d instr_pc", k), pc1, tbl[k].epc);
                chk($sformatf("tbl%0d instr", k), ins1, rom(tbl[k].epc));
                chk($sformatf("tbl%0d next_PC", k), npc1, tbl[k].epc + 32'd4);
            end
            @(posedge clk);
            #1;
        end

        // Randomized run; first cycle resets so the model starts in sync.
        for (int c = 0; c < 400; c++) begin
            rst   = (c == 0) || ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 30);
            rv    = ($urandom_range(0, 99) < 10);
            sel   = $urandom_range(0, 1);
            base  = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            imm   = 32'($urandom_range(0, 255)) - 32'd128;
            @(negedge clk);
            chk("rnd misaligned", {31'b0, mis1}, {31'b0, exp_mis(rv, sel, base, imm)});
            if (c > 0) begin
                chk("rnd instr_valid", {31'b0, v1}, {31'b0, m_valid});
                chk("rnd imem_addr", addr1, m_fetch);
                if (m_valid) begin
                    chk("rnd instr_pc", pc1, m_pc);
                    chk("rnd instr", ins1, rom(m_pc));
                    chk("rnd next_PC", npc1, m_pc + 32'd4);
                end
            end
            @(posedge clk);
            model_edge(rst, stall, rv, sel, base, imm);
            #1;
        end

        // Reset vector near the top of the address space wraps to 0.
        rst2 = 1'b0;
        @(negedge clk);
        chk("wrap reset valid", {31'b0, v2}, 32'h0);
        chk("wrap reset addr", addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFF8 + 32'(k * 4);
            @(negedge clk);
            chk($sformatf("wrap%0d valid", k), {31'b0, v2}, 32'h1);
            chk($sformatf("wrap%0d instr_pc", k), pc2, e);
            chk($sformatf("wrap%0d instr", k), ins2, rom(e));
            chk($sformatf("wrap%0d next_PC", k), npc2, e + 32'd4);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
